// File: rtl/core4_irq_pkg.sv
// Shared constants and helpers for the core4 interrupt controller.
package core4_irq_pkg;

  localparam int MAX_SRC      = 15;
  localparam int ID_VALID_BIT = 15;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_PENDING  = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] ADDR_ID       = 3'd4;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd5;

  // Lowest-numbered set bit wins; result is {valid, 11'b0, index}.
  function automatic logic [15:0] lowest_id(input logic [MAX_SRC-1:0] active);
    logic [15:0] id;
    id = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        id               = '0;
        id[ID_VALID_BIT] = 1'b1;
        id[3:0]          = 4'(i);
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/core4_irq_sync.sv
// Two-flop synchronizer for asynchronous interrupt request lines.
module core4_irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/core4_irq_ctrl.sv
// Interrupt aggregator with Avalon-MM register interface.
// Optional per-source edge capture: define CORE4_IRQ_CTRL_EDGE_CAPTURE_EN.
module core4_irq_ctrl
  import core4_irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  logic [NUM_SRC-1:0] s2;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] edge_sel_rd;
  logic [MAX_SRC-1:0] active_ext;
  logic [NUM_SRC-1:0] wdata;
  logic [15:0]        rd_val;
  logic               wr;
  logic               unused_wd;

  core4_irq_sync #(
    .WIDTH (NUM_SRC)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (irq_in),
    .q       (s2)
  );

  assign wr        = chipselect && !write_n;
  assign wdata     = writedata[NUM_SRC-1:0];
  assign unused_wd = ^writedata;
  assign active    = pending & mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
    end else if (wr && address == ADDR_MASK) begin
      mask <= wdata;
    end
  end

`ifdef CORE4_IRQ_CTRL_EDGE_CAPTURE_EN
  logic [NUM_SRC-1:0] s2_d;
  logic [NUM_SRC-1:0] edge_sel;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] edge_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_d     <= '0;
      edge_sel <= '0;
    end else begin
      s2_d <= s2;
      if (wr && address == ADDR_EDGE_SEL) begin
        edge_sel <= wdata;
      end
    end
  end

  assign rise     = s2 & ~s2_d;
  assign w1c      = (wr && address == ADDR_PENDING) ? wdata : '0;
  // Leaving edge mode drops the held event; level tracking picks up next cycle.
  assign edge_clr = (wr && address == ADDR_EDGE_SEL) ? (edge_sel & ~wdata) : '0;

  always_comb begin
    pending_next = s2;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_clr[i]) begin
        pending_next[i] = 1'b0;
      end else if (edge_sel[i]) begin
        // A new edge beats a simultaneous clear so the event is never lost.
        if (rise[i]) begin
          pending_next[i] = 1'b1;
        end else if (w1c[i]) begin
          pending_next[i] = 1'b0;
        end else begin
          pending_next[i] = pending[i];
        end
      end
    end
  end

  assign edge_sel_rd = edge_sel;
`else
  assign pending_next = s2;
  assign edge_sel_rd  = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= pending_next;
      irq     <= |(pending & mask);
    end
  end

  always_comb begin
    active_ext                = '0;
    active_ext[NUM_SRC-1:0]   = active;
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_STATUS:   rd_val[NUM_SRC-1:0] = s2;
      ADDR_PENDING:  rd_val[NUM_SRC-1:0] = pending;
      ADDR_MASK:     rd_val[NUM_SRC-1:0] = mask;
      ADDR_ACTIVE:   rd_val[NUM_SRC-1:0] = active;
      ADDR_ID:       rd_val              = lowest_id(active_ext);
      ADDR_EDGE_SEL: rd_val[NUM_SRC-1:0] = edge_sel_rd;
      default:       rd_val              = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_core4_irq_ctrl.sv
// Self-checking bench for core4_irq_ctrl: vector table plus multi-cycle sequences.
module tb_core4_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [3:0]  in;
    logic [15:0] mask;
    logic [2:0]  addr;
    logic [15:0] exp;
    logic        exp_irq;
    string       name;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  core4_irq_ctrl #(.NUM_SRC(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, required completion earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, {15'b0, irq}, {15'b0, exp});
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    sb_t e;
    address = a;
    e.name  = name;
    e.exp   = exp;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    check(e.name, readdata, e.exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vecs[0]  = '{4'b1010, 16'h000F, 3'd4, 16'h8001, 1'b1, "prio_all"};
    vecs[1]  = '{4'b1010, 16'h000C, 3'd4, 16'h8003, 1'b1, "prio_maskC"};
    vecs[2]  = '{4'b1010, 16'h000C, 3'd3, 16'h0008, 1'b1, "active_maskC"};
    vecs[3]  = '{4'b1010, 16'h0000, 3'd4, 16'h0000, 1'b0, "id_none"};
    vecs[4]  = '{4'b0101, 16'h000F, 3'd1, 16'h0005, 1'b1, "pending_lvl"};
    vecs[5]  = '{4'b0101, 16'h0006, 3'd3, 16'h0004, 1'b1, "active_mask6"};
    vecs[6]  = '{4'b0000, 16'h000F, 3'd4, 16'h0000, 1'b0, "id_idle"};
    vecs[7]  = '{4'b1111, 16'h0003, 3'd2, 16'h0003, 1'b1, "mask_rb"};
    vecs[8]  = '{4'b0100, 16'h000F, 3'd4, 16'h8002, 1'b1, "id_src2"};
    vecs[9]  = '{4'b0110, 16'hFFFF, 3'd2, 16'h000F, 1'b1, "mask_trunc"};
    vecs[10] = '{4'b0110, 16'h0000, 3'd5, 16'h0000, 1'b0, "edge_sel_rd"};
    vecs[11] = '{4'b1001, 16'h0008, 3'd0, 16'h0009, 1'b1, "status_rd"};
    vecs[12] = '{4'b1001, 16'h0008, 3'd4, 16'h8003, 1'b1, "id_src3"};

    reset_n    = 1'b0;
    irq_in     = 4'hF;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0000;

    // Reset behaviour with all requests high.
    ticks(3);
    chk_irq("rst_irq", 1'b0);
    check("rst_readdata", readdata, 16'h0000);
    reset_n = 1'b1;
    ticks(2);
    rd(3'd0, 16'h000F, "rst_status");
    rd(3'd1, 16'h000F, "rst_pending");
    rd(3'd3, 16'h0000, "rst_active");
    ticks(3);
    chk_irq("rst_irq_masked", 1'b0);

    // Mask write timing with a steady request.
    irq_in = 4'h1;
    ticks(4);
    wr(3'd2, 16'h0001);
    chk_irq("mask_edge_m", 1'b0);
    tick();
    chk_irq("mask_edge_m1", 1'b1);
    wr(3'd2, 16'h0000);
    chk_irq("unmask_edge_m", 1'b1);
    tick();
    chk_irq("unmask_edge_m1", 1'b0);

    // Level path latency, rise and fall.
    wr(3'd2, 16'h0004);
    irq_in = 4'h0;
    ticks(4);
    chk_irq("lvl_idle", 1'b0);
    irq_in = 4'h4;
    ticks(3);
    chk_irq("lvl_rise_e3", 1'b0);
    tick();
    chk_irq("lvl_rise_e4", 1'b1);
    irq_in = 4'h0;
    ticks(3);
    chk_irq("lvl_fall_e3", 1'b1);
    tick();
    chk_irq("lvl_fall_e4", 1'b0);

    // Vector table.
    foreach (vecs[k]) begin
      irq_in = vecs[k].in;
      wr(3'd2, vecs[k].mask);
      ticks(3);
      chk_irq({vecs[k].name, "_irq"}, vecs[k].exp_irq);
      rd(vecs[k].addr, vecs[k].exp, vecs[k].name);
    end

    // Writes to read-only and unmapped addresses are ignored.
    wr(3'd0, 16'hFFFF);
    wr(3'd3, 16'hFFFF);
    wr(3'd4, 16'hFFFF);
    wr(3'd6, 16'hFFFF);
`ifndef CORE4_IRQ_CTRL_EDGE_CAPTURE_EN
    wr(3'd1, 16'hFFFF);
    wr(3'd5, 16'hFFFF);
`endif
    rd(3'd2, 16'h0008, "ro_mask");
    rd(3'd0, 16'h0009, "ro_status");
    rd(3'd1, 16'h0009, "ro_pending");
    rd(3'd3, 16'h0008, "ro_active");
    rd(3'd4, 16'h8003, "ro_id");
    rd(3'd5, 16'h0000, "ro_edge_sel");
    rd(3'd6, 16'h0000, "unmapped6");
    rd(3'd7, 16'h0000, "unmapped7");

`ifdef CORE4_IRQ_CTRL_EDGE_CAPTURE_EN
    // Edge capture, write-1-to-clear, and set-beats-clear.
    wr(3'd2, 16'h0001);
    wr(3'd5, 16'h0001);
    irq_in = 4'h0;
    ticks(4);
    wr(3'd1, 16'h000F);
    tick();
    rd(3'd5, 16'h0001, "edge_sel_rb");
    rd(3'd1, 16'h0000, "edge_cleared");
    chk_irq("edge_idle", 1'b0);
    irq_in = 4'h1;
    ticks(2);
    irq_in = 4'h0;
    ticks(4);
    chk_irq("edge_held", 1'b1);
    rd(3'd1, 16'h0001, "edge_pending");
    wr(3'd1, 16'h0001);
    chk_irq("w1c_edge_w", 1'b1);
    tick();
    chk_irq("w1c_edge_w1", 1'b0);
    rd(3'd1, 16'h0000, "w1c_pending");
    irq_in = 4'h1;
    ticks(2);
    wr(3'd1, 16'h0001);
    rd(3'd1, 16'h0001, "set_beats_w1c");
    chk_irq("set_beats_w1c_irq", 1'b1);
    wr(3'd5, 16'h0000);
    rd(3'd1, 16'h0000, "edge_off_clear");
    rd(3'd1, 16'h0001, "edge_off_level");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
